usb_dir_arbiter: RTL and testbench
==================================

// Module: usb_dir_arbiter
// PURPOSE
//  Direction controller for the transparent USB full-speed snoop bridge. Watches both usb_fs_rx
//  instances and both usb_fs_tx pkt_end strobes, decides which link may forward at any time, and
//  gates the rx->tx routing so only one transmitter drives its bus. Sequences the token/data/handshake
//  exchange so a response is accepted only in its turnaround window; stale or unsolicited traffic is dropped.
// PARAMETERS
//  TURNAROUND_CYC  32     max clk_12mhz cycles from tx end to the opposite side's pkt_start
//  MAX_PKT_CYC     1500   watchdog: max cycles a forwarding state may last before abort
//  CNT_W           16     width of the transaction counter
// PORTS
//  clk_12mhz       in   1      bit-rate clock; all logic on posedge
//  reset_n         in   1      asynchronous, active-low reset
//  up_rx_pkt_start in   1      upstream (host side) receiver packet start strobe
//  up_rx_pkt_end   in   1      upstream receiver packet end strobe
//  up_rx_pid       in   4      upstream receiver PID, valid when up_rx_pkt_end=1
//  dn_rx_pkt_start in   1      downstream (device side) receiver packet start strobe
//  dn_rx_pkt_end   in   1      downstream receiver packet end strobe
//  dn_rx_pid       in   4      downstream receiver PID, valid when dn_rx_pkt_end=1
//  dn_tx_pkt_end   in   1      downstream transmitter finished driving (host->device copy done)
//  up_tx_pkt_end   in   1      upstream transmitter finished driving (device->host copy done)
//  fwd_h2d_en      out  1      gate: upstream rx -> downstream tx routing allowed
//  fwd_d2h_en      out  1      gate: downstream rx -> upstream tx routing allowed
//  busy            out  1      state != IDLE
//  timeout_pulse   out  1      1-cycle pulse: turnaround window expired
//  err_pulse       out  1      1-cycle pulse: unsolicited/colliding start or watchdog abort
//  txn_count       out  CNT_W  completed transactions (IDLE re-entered without error/timeout), wraps
// BEHAVIOUR
//  Reset (async on reset_n=0): state=IDLE, all outputs 0, timers 0, txn_count 0. Mid-packet reset
//   forces IDLE immediately; gates drop in the same cycle (combinational from state).
//  States: IDLE, H2D, WAIT_DEV, D2H, WAIT_HOST. fwd_h2d_en=1 in H2D; fwd_d2h_en=1 in D2H; else 0.
//   The gate is asserted in the cycle the pkt_start is seen (decoded from next-state) so the start
//   strobe itself is forwarded.
//  IDLE: up_rx_pkt_start -> H2D. dn_rx_pkt_start alone -> stay, err_pulse. Both same cycle -> H2D, err_pulse.
//  H2D: latch rx_done on up_rx_pkt_end and latch PID. Exit only on dn_tx_pkt_end with rx_done set
//   (or same cycle); dn_tx_pkt_end before rx_done is ignored. Exit by latched PID:
//   SOF(0101), ACK(0010), NAK(1010), STALL(1110) -> IDLE (txn_count+1);
//   OUT(0001), SETUP(1101) -> WAIT_HOST (host data phase follows); IN(1001), DATA0/1(0011/1011) -> WAIT_DEV;
//   any other PID -> IDLE, err_pulse.
//  WAIT_DEV: timer counts from 0; dn_rx_pkt_start -> D2H; up_rx_pkt_start -> H2D (host moved on,
//   no error); both -> H2D + err_pulse; timer reaching TURNAROUND_CYC-1 with no start -> IDLE + timeout_pulse.
//  D2H: mirror of H2D using dn_rx_pkt_end / up_tx_pkt_end. Exit: DATA0/1 -> WAIT_HOST;
//   ACK/NAK/STALL -> IDLE (txn_count+1); other -> IDLE + err_pulse.
//  WAIT_HOST: up_rx_pkt_start -> H2D; dn_rx_pkt_start -> stay + err_pulse; expiry -> IDLE + timeout_pulse.
//  Watchdog: cycles in H2D/D2H counted; reaching MAX_PKT_CYC-1 -> IDLE + err_pulse.
//  Timer is 0 on entry to every state; expiry and a start on the same cycle: start wins, no timeout.
//  txn_count wraps 2^CNT_W-1 -> 0 silently. timeout_pulse and err_pulse never both 1 on one cycle.
// STRUCTURE
//  usb_pid_pkg: PID localparams (OUT/IN/SOF/SETUP/DATA0/DATA1/ACK/NAK/STALL), state encoding,
//   shared with future PID-decode/logging blocks.
//  One sub-module usb_arb_timer: loadable up-counter with clear and expiry compare (instanced for
//   turnaround and watchdog). FSM, PID latch and rx_done flag stay in the top.
// TESTING
//  IN txn: host IN, dn_tx end, device DATA1 after 10 cyc, host ACK after 8 -> H2D,WAIT_DEV,D2H,WAIT_HOST,H2D,IDLE; txn_count=1.
//  OUT txn: OUT, DATA0, device NAK -> gates never overlap; txn_count=1; err/timeout never pulse.
//  Timeout: IN then no device start for 32 cyc -> IDLE on cycle 32, timeout_pulse exactly 1 cycle, fwd_d2h_en never 1.
//  Unsolicited: dn_rx_pkt_start in IDLE -> err_pulse, state IDLE, fwd_d2h_en=0; simultaneous starts -> H2D + err_pulse.
//  Boundary: device start on the expiry cycle of WAIT_DEV -> D2H, no timeout_pulse; dn_tx_pkt_end before up_rx_pkt_end ignored.
//  Reset/watchdog: reset_n low mid-D2H -> all outputs 0 asynchronously; stuck H2D 1500 cyc -> IDLE + err_pulse.

Source files
------------

// File: rtl/usb_pid_pkg.sv
// usb_pid_pkg: PID codes, arbiter state encoding and the PID-driven exit
// decisions for the snoop-bridge direction arbiter. Kept separate so
// PID-decode and logging blocks can share the same definitions.
package usb_pid_pkg;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_IN    = 4'b1001;
   localparam logic [3:0] PID_SOF   = 4'b0101;
   localparam logic [3:0] PID_SETUP = 4'b1101;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;
   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;

   typedef enum logic [2:0] {
      ST_IDLE, ST_H2D, ST_WAIT_DEV, ST_D2H, ST_WAIT_HOST
   } arb_state_t;

   // Side effect of a state decision; registered into the status pulses.
   typedef enum logic [1:0] {EV_NONE, EV_DONE, EV_ERR, EV_TMO} arb_ev_t;

   typedef struct packed {
      arb_state_t nxt;
      arb_ev_t    ev;
   } arb_exit_t;

   // Where a completed host->device packet leads, given its PID.
   function automatic arb_exit_t h2d_exit(input logic [3:0] pid);
      arb_exit_t r;
      r.nxt = ST_IDLE;
      r.ev  = EV_ERR;
      case (pid)
         PID_SOF, PID_ACK, PID_NAK, PID_STALL: r.ev = EV_DONE;
         PID_OUT, PID_SETUP: begin r.nxt = ST_WAIT_HOST; r.ev = EV_NONE; end
         PID_IN, PID_DATA0, PID_DATA1: begin r.nxt = ST_WAIT_DEV; r.ev = EV_NONE; end
         default: ;
      endcase
      return r;
   endfunction

   // Where a completed device->host packet leads, given its PID.
   function automatic arb_exit_t d2h_exit(input logic [3:0] pid);
      arb_exit_t r;
      r.nxt = ST_IDLE;
      r.ev  = EV_ERR;
      case (pid)
         PID_DATA0, PID_DATA1: begin r.nxt = ST_WAIT_HOST; r.ev = EV_NONE; end
         PID_ACK, PID_NAK, PID_STALL: r.ev = EV_DONE;
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/usb_arb_timer.sv
// usb_arb_timer: up-counter for the arbiter's turnaround and watchdog windows.
//  clk, rst_n : clock, async active-low reset
//  clr        : synchronous clear (state change) -- count restarts at 0
//  en         : count this cycle (owning state is active)
//  expired    : en and count has reached LIMIT-1 (last cycle of the window)
module usb_arb_timer #(
   parameter int unsigned LIMIT = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    cnt <= '0;
      else if (clr)  cnt <= '0;
      else if (en)   cnt <= cnt + 1'b1;
   end

   assign expired = en && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/usb_dir_arbiter.sv
// usb_dir_arbiter: direction controller for the transparent USB full-speed
// snoop bridge. Tracks token/data/handshake turnaround and gates rx->tx
// routing so only one side's transmitter drives at a time.
//  clk_12mhz, reset_n          : bit-rate clock, async active-low reset
//  up_rx_pkt_start/end, pid    : host-side receiver strobes and PID
//  dn_rx_pkt_start/end, pid    : device-side receiver strobes and PID
//  dn_tx_pkt_end, up_tx_pkt_end: transmitter copy-finished strobes
//  fwd_h2d_en, fwd_d2h_en      : routing gates (include the start cycle)
//  busy                        : not idle
//  timeout_pulse, err_pulse    : 1-cycle status pulses
//  txn_count                   : completed transactions, wraps
module usb_dir_arbiter import usb_pid_pkg::*; #(
   parameter int unsigned TURNAROUND_CYC = 32,
   parameter int unsigned MAX_PKT_CYC    = 1500,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk_12mhz,
   input  logic             reset_n,
   input  logic             up_rx_pkt_start,
   input  logic             up_rx_pkt_end,
   input  logic [3:0]       up_rx_pid,
   input  logic             dn_rx_pkt_start,
   input  logic             dn_rx_pkt_end,
   input  logic [3:0]       dn_rx_pid,
   input  logic             dn_tx_pkt_end,
   input  logic             up_tx_pkt_end,
   output logic             fwd_h2d_en,
   output logic             fwd_d2h_en,
   output logic             busy,
   output logic             timeout_pulse,
   output logic             err_pulse,
   output logic [CNT_W-1:0] txn_count
);

   arb_state_t state_q, state_d;
   arb_ev_t    ev_d;
   arb_exit_t  ex;
   logic       rx_done;
   logic [3:0] pid_q;
   logic       ta_exp, wd_exp, tmr_clr;
   logic       h2d_done, d2h_done;
   logic [3:0] h2d_pid, d2h_pid;

   // An rx end coinciding with the tx end still counts; use the live PID then.
   assign h2d_done = rx_done | up_rx_pkt_end;
   assign h2d_pid  = up_rx_pkt_end ? up_rx_pid : pid_q;
   assign d2h_done = rx_done | dn_rx_pkt_end;
   assign d2h_pid  = dn_rx_pkt_end ? dn_rx_pid : pid_q;

   assign tmr_clr = (state_d != state_q);

   usb_arb_timer #(.LIMIT(TURNAROUND_CYC)) u_ta_tmr (
      .clk     (clk_12mhz),
      .rst_n   (reset_n),
      .clr     (tmr_clr),
      .en      ((state_q == ST_WAIT_DEV) || (state_q == ST_WAIT_HOST)),
      .expired (ta_exp)
   );

   usb_arb_timer #(.LIMIT(MAX_PKT_CYC)) u_wd_tmr (
      .clk     (clk_12mhz),
      .rst_n   (reset_n),
      .clr     (tmr_clr),
      .en      ((state_q == ST_H2D) || (state_q == ST_D2H)),
      .expired (wd_exp)
   );

   always_comb begin
      state_d = state_q;
      ev_d    = EV_NONE;
      ex      = '0;
      case (state_q)
         ST_IDLE: begin
            if (up_rx_pkt_start) state_d = ST_H2D;
            if (dn_rx_pkt_start) ev_d = EV_ERR;
         end
         ST_H2D: begin
            if (dn_tx_pkt_end && h2d_done) begin
               ex      = h2d_exit(h2d_pid);
               state_d = ex.nxt;
               ev_d    = ex.ev;
            end else if (wd_exp) begin
               state_d = ST_IDLE;
               ev_d    = EV_ERR;
            end
         end
         ST_D2H: begin
            if (up_tx_pkt_end && d2h_done) begin
               ex      = d2h_exit(d2h_pid);
               state_d = ex.nxt;
               ev_d    = ex.ev;
            end else if (wd_exp) begin
               state_d = ST_IDLE;
               ev_d    = EV_ERR;
            end
         end
         ST_WAIT_DEV, ST_WAIT_HOST: begin
            // Host start always wins; a start on the expiry cycle beats the timeout.
            if (up_rx_pkt_start) begin
               state_d = ST_H2D;
               if (dn_rx_pkt_start) ev_d = EV_ERR;
            end else if (dn_rx_pkt_start) begin
               if (state_q == ST_WAIT_DEV) state_d = ST_D2H;
               else                        ev_d    = EV_ERR;
            end else if (ta_exp) begin
               state_d = ST_IDLE;
               ev_d    = EV_TMO;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         rx_done       <= 1'b0;
         pid_q         <= '0;
         timeout_pulse <= 1'b0;
         err_pulse     <= 1'b0;
         txn_count     <= '0;
      end else begin
         state_q       <= state_d;
         timeout_pulse <= (ev_d == EV_TMO);
         err_pulse     <= (ev_d == EV_ERR);
         if (ev_d == EV_DONE) txn_count <= txn_count + 1'b1;
         if (state_d != state_q) begin
            rx_done <= 1'b0;
         end else if ((state_q == ST_H2D && up_rx_pkt_end) ||
                      (state_q == ST_D2H && dn_rx_pkt_end)) begin
            rx_done <= 1'b1;
            pid_q   <= (state_q == ST_H2D) ? up_rx_pid : dn_rx_pid;
         end
      end
   end

   // Gates cover the start cycle (next state) and the exit cycle (current
   // state); forced low while reset is held so a mid-packet reset cuts at once.
   assign fwd_h2d_en = reset_n && ((state_q == ST_H2D) || (state_d == ST_H2D));
   assign fwd_d2h_en = reset_n && ((state_q == ST_D2H) || (state_d == ST_D2H));
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usb_dir_arbiter.sv
module tb_usb_dir_arbiter;

   localparam int TA = 32;
   localparam int WD = 1500;
   localparam int CW = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic us = 0, ue = 0, ds = 0, de = 0, dte = 0, ute = 0;
   logic [3:0] up = 0, dp = 0;
   logic h2d, d2h, busy, tmo, err;
   logic [CW-1:0] cnt;

   always #5 clk = ~clk;

   usb_dir_arbiter #(.TURNAROUND_CYC(TA), .MAX_PKT_CYC(WD), .CNT_W(CW)) dut (
      .clk_12mhz(clk), .reset_n(rst_n),
      .up_rx_pkt_start(us), .up_rx_pkt_end(ue), .up_rx_pid(up),
      .dn_rx_pkt_start(ds), .dn_rx_pkt_end(de), .dn_rx_pid(dp),
      .dn_tx_pkt_end(dte), .up_tx_pkt_end(ute),
      .fwd_h2d_en(h2d), .fwd_d2h_en(d2h), .busy(busy),
      .timeout_pulse(tmo), .err_pulse(err), .txn_count(cnt));

   typedef struct {
      logic us, ue, ds, de, dte, ute;
      logic [3:0] up, dp;
   } in_t;

   typedef struct {
      in_t i;
      int reps;
      logic [4:0] o;   // {h2d, d2h, busy, timeout, err}
      int cnt;
   } vec_t;

   vec_t tbl[$];
   int checks = 0, failures = 0;

   // Reference model: phase 0 idle, 1 host sending, 2 waiting for device,
   // 3 device sending, 4 waiting for host; age = cycles spent in the phase.
   int m_ph, m_age, m_cnt, n_ph, n_ev;   // n_ev: 0 none, 1 done, 2 err, 3 timeout
   bit m_done, m_to, m_err;
   bit [3:0] m_pid;

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
      end
   endtask

   task automatic route(input bit host, input bit [3:0] p, output int ph, output int ev);
      if (host) begin
         if (p inside {4'h5, 4'h2, 4'hA, 4'hE})      begin ph = 0; ev = 1; end
         else if (p inside {4'h1, 4'hD})             begin ph = 4; ev = 0; end
         else if (p inside {4'h9, 4'h3, 4'hB})       begin ph = 2; ev = 0; end
         else                                        begin ph = 0; ev = 2; end
      end else begin
         if (p inside {4'h3, 4'hB})                  begin ph = 4; ev = 0; end
         else if (p inside {4'h2, 4'hA, 4'hE})       begin ph = 0; ev = 1; end
         else                                        begin ph = 0; ev = 2; end
      end
   endtask

   task automatic model_eval(input in_t i);
      n_ph = m_ph; n_ev = 0;
      case (m_ph)
         0: begin
            if (i.us) n_ph = 1;
            if (i.ds) n_ev = 2;
         end
         1: if (i.dte && (m_done || i.ue)) route(1, i.ue ? i.up : m_pid, n_ph, n_ev);
            else if (m_age == WD - 1) begin n_ph = 0; n_ev = 2; end
         3: if (i.ute && (m_done || i.de)) route(0, i.de ? i.dp : m_pid, n_ph, n_ev);
            else if (m_age == WD - 1) begin n_ph = 0; n_ev = 2; end
         default: begin
            if (i.us) begin n_ph = 1; if (i.ds) n_ev = 2; end
            else if (i.ds) begin if (m_ph == 2) n_ph = 3; else n_ev = 2; end
            else if (m_age == TA - 1) begin n_ph = 0; n_ev = 3; end
         end
      endcase
   endtask

   task automatic model_commit(input in_t i);
      m_to  = (n_ev == 3);
      m_err = (n_ev == 2);
      if (n_ev == 1) m_cnt = (m_cnt + 1) % (1 << CW);
      if (n_ph != m_ph) begin
         m_ph = n_ph; m_age = 0; m_done = 0;
      end else begin
         m_age++;
         if (m_ph == 1 && i.ue) begin m_done = 1; m_pid = i.up; end
         if (m_ph == 3 && i.de) begin m_done = 1; m_pid = i.dp; end
      end
   endtask

   task automatic model_reset();
      m_ph = 0; m_age = 0; m_cnt = 0; m_done = 0; m_to = 0; m_err = 0; m_pid = 0;
   endtask

   // One clock: drive after the edge, check on the falling edge, advance model.
   task automatic step(input in_t i, input bit use_exp, input logic [4:0] eo,
                       input int ec, input string nm);
      logic [4:0] got, mo;
      us = i.us; ue = i.ue; up = i.up; ds = i.ds; de = i.de; dp = i.dp;
      dte = i.dte; ute = i.ute;
      @(negedge clk);
      model_eval(i);
      got = {h2d, d2h, busy, tmo, err};
      mo  = {(m_ph == 1 || n_ph == 1), (m_ph == 3 || n_ph == 3), (m_ph != 0), m_to, m_err};
      cmp({nm, "/out"}, got, mo);
      cmp({nm, "/cnt"}, cnt, m_cnt);
      cmp({nm, "/excl"}, {h2d & d2h, tmo & err}, 2'b00);
      if (use_exp) begin
         cmp({nm, "/vec_out"}, got, eo);
         cmp({nm, "/vec_cnt"}, cnt, ec[CW-1:0]);
      end
      @(posedge clk);
      model_commit(i);
      #1;
   endtask

   function automatic in_t mk(input string s, input logic [3:0] u, input logic [3:0] d);
      in_t i;
      i = '{default: 0};
      i.up = u; i.dp = d;
      for (int k = 0; k < s.len(); k++)
         case (s[k])
            "S": i.us = 1;   "E": i.ue = 1;
            "s": i.ds = 1;   "e": i.de = 1;
            "T": i.dte = 1;  "t": i.ute = 1;
            default: ;
         endcase
      return i;
   endfunction

   task automatic row(input string s, input logic [3:0] u, input logic [3:0] d,
                      input int reps, input logic [4:0] o, input int c);
      vec_t v;
      v.i = mk(s, u, d); v.reps = reps; v.o = o; v.cnt = c;
      tbl.push_back(v);
   endtask

   initial begin
      model_reset();
      #3;
      cmp("reset", {h2d, d2h, busy, tmo, err, 4'(cnt)}, 9'd0);
      #9 rst_n = 1'b1;
      @(posedge clk); #1;

      // IN transaction: IN, device DATA1 after 10, host ACK after 8
      row("",   0, 0,  2, 5'b00000, 0);
      row("S",  0, 0,  1, 5'b10000, 0);
      row("",   0, 0,  3, 5'b10100, 0);
      row("E",  4'b1001, 0, 1, 5'b10100, 0);
      row("",   0, 0,  2, 5'b10100, 0);
      row("T",  0, 0,  1, 5'b10100, 0);
      row("",   0, 0, 10, 5'b00100, 0);
      row("s",  0, 0,  1, 5'b01100, 0);
      row("",   0, 0,  3, 5'b01100, 0);
      row("e",  0, 4'b1011, 1, 5'b01100, 0);
      row("t",  0, 0,  1, 5'b01100, 0);
      row("",   0, 0,  8, 5'b00100, 0);
      row("S",  0, 0,  1, 5'b10100, 0);
      row("",   0, 0,  2, 5'b10100, 0);
      row("E",  4'b0010, 0, 1, 5'b10100, 0);
      row("T",  0, 0,  1, 5'b10100, 0);
      row("",   0, 0,  2, 5'b00000, 1);
      // OUT transaction: OUT, DATA0 (rx end and tx end together), device NAK
      row("S",  0, 0,  1, 5'b10000, 1);
      row("E",  4'b0001, 0, 1, 5'b10100, 1);
      row("T",  0, 0,  1, 5'b10100, 1);
      row("",   0, 0,  4, 5'b00100, 1);
      row("S",  0, 0,  1, 5'b10100, 1);
      row("ET", 4'b0011, 0, 1, 5'b10100, 1);
      row("",   0, 0,  5, 5'b00100, 1);
      row("s",  0, 0,  1, 5'b01100, 1);
      row("e",  0, 4'b1010, 1, 5'b01100, 1);
      row("t",  0, 0,  1, 5'b01100, 1);
      row("",   0, 0,  2, 5'b00000, 2);
      // Turnaround timeout after IN
      row("S",  0, 0,  1, 5'b10000, 2);
      row("ET", 4'b1001, 0, 1, 5'b10100, 2);
      row("",   0, 0, 32, 5'b00100, 2);
      row("",   0, 0,  1, 5'b00010, 2);
      row("",   0, 0,  1, 5'b00000, 2);
      // Device start on the expiry cycle wins
      row("S",  0, 0,  1, 5'b10000, 2);
      row("ET", 4'b1001, 0, 1, 5'b10100, 2);
      row("",   0, 0, 31, 5'b00100, 2);
      row("s",  0, 0,  1, 5'b01100, 2);
      row("et", 0, 4'b0010, 1, 5'b01100, 2);
      row("",   0, 0,  1, 5'b00000, 3);
      // tx end before rx end is ignored
      row("S",  0, 0,  1, 5'b10000, 3);
      row("T",  0, 0,  1, 5'b10100, 3);
      row("",   0, 0,  1, 5'b10100, 3);
      row("E",  4'b0101, 0, 1, 5'b10100, 3);
      row("T",  0, 0,  1, 5'b10100, 3);
      row("",   0, 0,  1, 5'b00000, 4);
      // Unsolicited device start, then simultaneous starts
      row("s",  0, 0,  1, 5'b00000, 4);
      row("",   0, 0,  1, 5'b00001, 4);
      row("",   0, 0,  1, 5'b00000, 4);
      row("Ss", 0, 0,  1, 5'b10000, 4);
      row("",   0, 0,  1, 5'b10101, 4);
      row("ET", 4'b0101, 0, 1, 5'b10100, 4);
      row("",   0, 0,  1, 5'b00000, 5);
      // Unknown PID from host
      row("S",  0, 0,  1, 5'b10000, 5);
      row("ET", 4'b0000, 0, 1, 5'b10100, 5);
      row("",   0, 0,  1, 5'b00001, 5);
      row("",   0, 0,  1, 5'b00000, 5);
      // Device start while waiting for host, then timeout
      row("S",  0, 0,  1, 5'b10000, 5);
      row("ET", 4'b1101, 0, 1, 5'b10100, 5);
      row("s",  0, 0,  1, 5'b00100, 5);
      row("",   0, 0,  1, 5'b00101, 5);
      row("",   0, 0, 30, 5'b00100, 5);
      row("",   0, 0,  1, 5'b00010, 5);
      row("",   0, 0,  1, 5'b00000, 5);
      // Watchdog on a stuck host packet
      row("S",  0, 0,  1, 5'b10000, 5);
      row("",   0, 0, WD, 5'b10100, 5);
      row("",   0, 0,  1, 5'b00001, 5);
      row("",   0, 0,  1, 5'b00000, 5);

      foreach (tbl[n])
         for (int r = 0; r < tbl[n].reps; r++)
            step(tbl[n].i, 1'b1, tbl[n].o, tbl[n].cnt, $sformatf("row%0d", n));

      // Drive txn_count through its wrap
      for (int k = 0; k < 12; k++) begin
         step(mk("S", 0, 0), 0, 0, 0, "wrap_s");
         step(mk("ET", 4'b0101, 0), 0, 0, 0, "wrap_e");
      end
      cmp("wrap_value", cnt, 4'd1);

      // Async reset in the middle of a device packet
      step(mk("S", 0, 0), 0, 0, 0, "rst_s");
      step(mk("ET", 4'b1001, 0), 0, 0, 0, "rst_in");
      step(mk("s", 0, 0), 0, 0, 0, "rst_ds");
      step(mk("", 0, 0), 0, 0, 0, "rst_d2h");
      us = 1; ds = 1;
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst", {h2d, d2h, busy, tmo, err, 4'(cnt)}, 9'd0);
      @(negedge clk);
      us = 0; ds = 0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();

      // Random traffic against the model
      for (int k = 0; k < 4000; k++) begin
         in_t i;
         i.us  = ($urandom_range(0, 15) == 0);
         i.ds  = ($urandom_range(0, 15) == 0);
         i.ue  = ($urandom_range(0, 5) == 0);
         i.de  = ($urandom_range(0, 5) == 0);
         i.dte = ($urandom_range(0, 5) == 0);
         i.ute = ($urandom_range(0, 5) == 0);
         i.up  = 4'($urandom_range(0, 15));
         i.dp  = 4'($urandom_range(0, 15));
         step(i, 0, 0, 0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
